video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised, runtime-reprogrammable raster timing generator for the display path. It produces sync, blanking and pixel-coordinate signals for any mode that fits the counter width, and switches modes glitch-free at frame boundaries. It also emits a fetch-side coordinate stream LOOKAHEAD cycles ahead of the display-side stream, so the scanout/framebuffer-read pipeline can be primed. It sits between the pixel clock domain root and the scanout/DVI encoder.

## Interface
- CW, 11: counter/coordinate width; timing totals must be below 2^CW.
- LOOKAHEAD, 4: cycles by which fetch outputs lead display outputs; valid range 0..15.
- HS_POL, 0: hsync level during the pulse.
- VS_POL, 0: vsync level during the pulse.
- DEF_H_ACT/H_FP/H_SYNC/H_BP, 640/16/96/48: reset-time horizontal mode.
- DEF_V_ACT/V_FP/V_SYNC/V_BP, 480/10/2/33: reset-time vertical mode.
- clk_pixel  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- cfg_valid  in  1  new mode offered
- cfg_ready  out  1  no mode change pending; offer accepted when valid&ready
- cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  horizontal segment lengths
- cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  vertical segment lengths
- fetch_valid  out  1  fetch coordinate is an active pixel
- fetch_x, fetch_y  out  CW  fetch coordinate; 0 when not active
- fetch_line_start  out  1  first active pixel of each active line (fetch side)
- hsync, vsync  out  1  sync, display side
- display_enable  out  1  active region, display side
- pixel_x, pixel_y  out  CW  display coordinate; 0 when blanked
- frame_start  out  1  display-side pulse at position (0,0)
- vblank_start  out  1  display-side pulse at (0, v_act)

## Operation
- Live mode registers are H_TOT = act+fp+sync+bp and V_TOT likewise; the segment boundaries are precomputed into registers whenever the live mode changes.
- Reset loads the DEF_* values, clears h_cnt/v_cnt to 0 and sets cfg_ready=1.
- h_cnt increments every cycle and wraps at H_TOT-1. v_cnt increments on each h wrap and wraps at V_TOT-1.
- Config handshake: on valid&ready the cfg_* values are captured into a shadow register and cfg_ready drops to 0.
  - The shadow is applied at end of frame, i.e. in the cycle h_cnt=H_TOT-1 and v_cnt=V_TOT-1; the counters still wrap to 0.
  - cfg_ready returns to 1 the cycle after the shadow is applied.
  - The live mode never changes mid-frame.
- Fetch stage is registered from the counters:
  - fetch_valid = (h_cnt<H_ACT)&&(v_cnt<V_ACT).
  - fetch_x/y = counters when fetch_valid, else 0.
  - fetch_line_start = fetch_valid&&h_cnt==0.
- Display stage is a LOOKAHEAD-deep shift register of the fetch-stage bundle {active, x, y, hs, vs, fs, vbs}:
  - hs_raw = h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC).
  - vs_raw = v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC).
  - hsync = hs_raw ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
- Zero-length segments are legal for fp/sync/bp. A zero sync length never asserts sync. act=0 is illegal and gives undefined behaviour.

## Timing
- Fetch outputs follow the counters by 1 cycle. Display outputs follow the counters by 1+LOOKAHEAD cycles. With LOOKAHEAD=0 the display and fetch outputs are cycle-aligned.
- Reset values, fetch side: fetch_valid=0, fetch_x=0, fetch_y=0, fetch_line_start=0.
- Reset values, display side: all pipeline stages are cleared. display_enable=0, pixel_x=0, pixel_y=0, frame_start=0, vblank_start=0, hsync=~HS_POL, vsync=~VS_POL.
- The first frame_start is asserted 1+LOOKAHEAD cycles after rst_n rises.
- Reset asserted mid-frame or mid-handshake: the shadow is discarded, DEF mode is restored and cfg_ready=1 on the next cycle.
- cfg_valid held while cfg_ready=0 is ignored.
- An offer accepted in the very cycle of end of frame is applied at the next end of frame, not the current one.

## Test plan
- Default mode, LOOKAHEAD=4 -> H_TOT=800, V_TOT=525.
  - hsync low for 96 cycles starting 656+5 cycles after each line start.
  - display_enable high 640 cycles per line and on 480 lines.
  - frame_start period exactly 420000 cycles.
- Fetch/display alignment -> at every cycle, the display bundle equals the fetch bundle from 4 cycles earlier; fetch_line_start occurs 480 times per frame.
- Mid-frame cfg offer of 800x600 (40/128/88, 1/4/23) at v_cnt=100 -> cfg_ready falls the next cycle.
  - The old frame completes unchanged.
  - The next frame has H_TOT=1056, V_TOT=628.
  - cfg_ready rises one cycle after the switch.
- Second offer while pending -> not accepted; the first mode is applied.
- HS_POL=1, VS_POL=1 -> sync pulses are high and idle is low; reset value of hsync is 0.
- rst_n pulsed mid-line with a pending config -> all outputs hold reset values; DEF mode resumes with counters at 0; the pending mode is never applied.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Mode-change offer from the display controller to the raster timing generator.
// A new mode is handed over with a valid/ready handshake.
interface video_timing_gen_if #(
    parameter int CW = 11
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_h_act;
    logic [CW-1:0] cfg_h_fp;
    logic [CW-1:0] cfg_h_sync;
    logic [CW-1:0] cfg_h_bp;
    logic [CW-1:0] cfg_v_act;
    logic [CW-1:0] cfg_v_fp;
    logic [CW-1:0] cfg_v_sync;
    logic [CW-1:0] cfg_v_bp;

    modport master (
        output cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
        output cfg_ready
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with a fetch stream leading the display stream by LOOKAHEAD cycles.
// Latency: fetch outputs 1 cycle after the counters, display outputs 1+LOOKAHEAD cycles after.
// Backpressure: none on the raster; cfg_ready stays low while a mode change waits for end of frame.
module video_timing_gen #(
    parameter int CW        = 11,
    parameter int LOOKAHEAD = 4,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int DEF_H_ACT = 640,
    parameter int DEF_H_FP  = 16,
    parameter int DEF_H_SYNC = 96,
    parameter int DEF_H_BP  = 48,
    parameter int DEF_V_ACT = 480,
    parameter int DEF_V_FP  = 10,
    parameter int DEF_V_SYNC = 2,
    parameter int DEF_V_BP  = 33
) (
    input  logic                clk_pixel,
    input  logic                rst_n,
    video_timing_gen_if.slave   cfg,
    output logic                fetch_valid,
    output logic [CW-1:0]       fetch_x,
    output logic [CW-1:0]       fetch_y,
    output logic                fetch_line_start,
    output logic                hsync,
    output logic                vsync,
    output logic                display_enable,
    output logic [CW-1:0]       pixel_x,
    output logic [CW-1:0]       pixel_y,
    output logic                frame_start,
    output logic                vblank_start
);

    // Per-axis segment boundaries: active end, sync start, sync end, last count.
    typedef struct packed {
        logic [CW-1:0] act;
        logic [CW-1:0] ss;
        logic [CW-1:0] se;
        logic [CW-1:0] tm1;
    } seg_t;

    typedef struct packed {
        logic          act;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          vbs;
    } pix_t;

    function automatic seg_t mk_seg(input logic [CW-1:0] act, input logic [CW-1:0] fp,
                                    input logic [CW-1:0] sync, input logic [CW-1:0] bp);
        seg_t s;
        s.act = act;
        s.ss  = act + fp;
        s.se  = act + fp + sync;
        s.tm1 = act + fp + sync + bp - CW'(1);
        return s;
    endfunction

    localparam seg_t H_DEF = mk_seg(CW'(DEF_H_ACT), CW'(DEF_H_FP), CW'(DEF_H_SYNC), CW'(DEF_H_BP));
    localparam seg_t V_DEF = mk_seg(CW'(DEF_V_ACT), CW'(DEF_V_FP), CW'(DEF_V_SYNC), CW'(DEF_V_BP));

    seg_t          h_live, v_live, h_shad, v_shad;
    logic          pending;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap, eof;

    assign h_wrap        = (h_cnt == h_live.tm1);
    assign v_wrap        = (v_cnt == v_live.tm1);
    assign eof           = h_wrap && v_wrap;
    assign cfg.cfg_ready = ~pending;

    // Apply takes priority so an offer landing on end of frame waits a whole frame.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            h_live  <= H_DEF;
            v_live  <= V_DEF;
            h_shad  <= H_DEF;
            v_shad  <= V_DEF;
            pending <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + CW'(1);
            if (h_wrap)
                v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
            if (pending && eof) begin
                h_live  <= h_shad;
                v_live  <= v_shad;
                pending <= 1'b0;
            end else if (cfg.cfg_valid && !pending) begin
                h_shad  <= mk_seg(cfg.cfg_h_act, cfg.cfg_h_fp, cfg.cfg_h_sync, cfg.cfg_h_bp);
                v_shad  <= mk_seg(cfg.cfg_v_act, cfg.cfg_v_fp, cfg.cfg_v_sync, cfg.cfg_v_bp);
                pending <= 1'b1;
            end
        end
    end

    pix_t nxt, fet, dsp;
    logic nxt_ls, fet_ls;

    always_comb begin
        nxt     = '0;
        nxt.act = (h_cnt < h_live.act) && (v_cnt < v_live.act);
        nxt.x   = nxt.act ? h_cnt : '0;
        nxt.y   = nxt.act ? v_cnt : '0;
        nxt.hs  = (h_cnt >= h_live.ss) && (h_cnt < h_live.se);
        nxt.vs  = (v_cnt >= v_live.ss) && (v_cnt < v_live.se);
        nxt.fs  = (h_cnt == '0) && (v_cnt == '0);
        nxt.vbs = (h_cnt == '0) && (v_cnt == v_live.act);
        nxt_ls  = nxt.act && (h_cnt == '0);
    end

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            fet    <= '0;
            fet_ls <= 1'b0;
        end else begin
            fet    <= nxt;
            fet_ls <= nxt_ls;
        end
    end

    generate
        if (LOOKAHEAD == 0) begin : g_no_delay
            assign dsp = fet;
        end else begin : g_delay
            pix_t pipe [LOOKAHEAD];
            always_ff @(posedge clk_pixel) begin
                if (!rst_n) begin
                    for (int i = 0; i < LOOKAHEAD; i++)
                        pipe[i] <= '0;
                end else begin
                    pipe[0] <= fet;
                    for (int i = 1; i < LOOKAHEAD; i++)
                        pipe[i] <= pipe[i-1];
                end
            end
            assign dsp = pipe[LOOKAHEAD-1];
        end
    endgenerate

    assign fetch_valid      = fet.act;
    assign fetch_x          = fet.x;
    assign fetch_y          = fet.y;
    assign fetch_line_start = fet_ls;
    assign display_enable   = dsp.act;
    assign pixel_x          = dsp.x;
    assign pixel_y          = dsp.y;
    assign hsync            = dsp.hs ? HS_POL : ~HS_POL;
    assign vsync            = dsp.vs ? VS_POL : ~VS_POL;
    assign frame_start      = dsp.fs;
    assign vblank_start     = dsp.vbs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using small modes so whole frames stay short.
// Mode A (default) 8/2/3/2 x 4/1/2/1, mode B 6/1/2/3 x 3/1/1/2, mode C 5/0/0/1 x 2/0/0/1.
module tb_video_timing_gen;
    localparam int CW = 8;

    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;
    logic rst_n;

    video_timing_gen_if #(.CW(CW)) cfg_if ();
    video_timing_gen_if #(.CW(CW)) pol_if ();

    logic          fetch_valid, fetch_line_start, hsync, vsync, display_enable, frame_start, vblank_start;
    logic [CW-1:0] fetch_x, fetch_y, pixel_x, pixel_y;
    logic          p_fetch_valid, p_fetch_line_start, p_hsync, p_vsync, p_display_enable, p_frame_start, p_vblank_start;
    logic [CW-1:0] p_fetch_x, p_fetch_y, p_pixel_x, p_pixel_y;

    video_timing_gen #(
        .CW(CW), .LOOKAHEAD(4), .HS_POL(1'b0), .VS_POL(1'b0),
        .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
        .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1)
    ) u_dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .cfg(cfg_if.slave),
        .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
        .fetch_line_start(fetch_line_start), .hsync(hsync), .vsync(vsync),
        .display_enable(display_enable), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .vblank_start(vblank_start)
    );

    video_timing_gen #(
        .CW(CW), .LOOKAHEAD(4), .HS_POL(1'b1), .VS_POL(1'b1),
        .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
        .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1)
    ) u_pol (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .cfg(pol_if.slave),
        .fetch_valid(p_fetch_valid), .fetch_x(p_fetch_x), .fetch_y(p_fetch_y),
        .fetch_line_start(p_fetch_line_start), .hsync(p_hsync), .vsync(p_vsync),
        .display_enable(p_display_enable), .pixel_x(p_pixel_x), .pixel_y(p_pixel_y),
        .frame_start(p_frame_start), .vblank_start(p_vblank_start)
    );

    int total = 0;
    int bad   = 0;

    // Per-frame measurements, indexed from the frame_start cycle.
    int m_period, m_de, m_hs, m_hs_first, m_vs, m_vs_first, m_vbs_off, m_ls, m_phs_hi, m_pneq;
    int px [0:255];
    int py [0:255];

    task automatic tick;
        @(negedge clk_pixel);
    endtask

    task automatic drive_cfg(input logic v, input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb);
        cfg_if.cfg_valid  = v;
        cfg_if.cfg_h_act  = CW'(ha);
        cfg_if.cfg_h_fp   = CW'(hf);
        cfg_if.cfg_h_sync = CW'(hs);
        cfg_if.cfg_h_bp   = CW'(hb);
        cfg_if.cfg_v_act  = CW'(va);
        cfg_if.cfg_v_fp   = CW'(vf);
        cfg_if.cfg_v_sync = CW'(vs);
        cfg_if.cfg_v_bp   = CW'(vb);
    endtask

    // Starts at a frame_start (now or upcoming) and measures until the next one.
    task automatic measure_frame;
        int w;
        m_period = -1; m_de = 0; m_hs = 0; m_hs_first = -1; m_vs = 0; m_vs_first = -1;
        m_vbs_off = -1; m_ls = 0; m_phs_hi = 0; m_pneq = 0;
        w = 0;
        while (frame_start !== 1'b1 && w < 500) begin tick(); w++; end
        if (frame_start !== 1'b1) return;
        for (int i = 0; i < 500; i++) begin
            if (i > 0 && frame_start === 1'b1) begin m_period = i; break; end
            if (display_enable === 1'b1) m_de++;
            if (hsync === 1'b0) begin m_hs++; if (m_hs_first < 0) m_hs_first = i; end
            if (vsync === 1'b0) begin m_vs++; if (m_vs_first < 0) m_vs_first = i; end
            if (vblank_start === 1'b1 && m_vbs_off < 0) m_vbs_off = i;
            if (fetch_line_start === 1'b1) m_ls++;
            if (p_hsync === 1'b1) m_phs_hi++;
            if (p_hsync !== ~hsync) m_pneq++;
            if (i < 256) begin px[i] = int'(pixel_x); py[i] = int'(pixel_y); end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_cfg(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        pol_if.cfg_valid = 1'b0;
        {pol_if.cfg_h_act, pol_if.cfg_h_fp, pol_if.cfg_h_sync, pol_if.cfg_h_bp} = '0;
        {pol_if.cfg_v_act, pol_if.cfg_v_fp, pol_if.cfg_v_sync, pol_if.cfg_v_bp} = '0;
        repeat (4) tick();
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cfg_if.cfg_ready); end
        total++; if ({fetch_valid, fetch_line_start, display_enable, frame_start, vblank_start} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {fetch_valid, fetch_line_start, display_enable, frame_start, vblank_start}); end
        total++; if ({fetch_x, fetch_y, pixel_x, pixel_y} !== '0) begin bad++; $display("FAIL rst_coords got=%h exp=0", {fetch_x, fetch_y, pixel_x, pixel_y}); end
        total++; if ({hsync, vsync} !== 2'b11) begin bad++; $display("FAIL rst_sync got=%b exp=11", {hsync, vsync}); end
        total++; if ({p_hsync, p_vsync} !== 2'b00) begin bad++; $display("FAIL rst_pol_sync got=%b exp=00", {p_hsync, p_vsync}); end
    endtask

    task automatic test_first_frame;
        int n;
        rst_n = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 50) begin tick(); n++; end
        total++; if (n !== 5) begin bad++; $display("FAIL first_fs got=%0d exp=5", n); end
        total++; if (display_enable !== 1'b1 || pixel_x !== '0 || pixel_y !== '0) begin bad++; $display("FAIL first_pix got=%b/%0d/%0d exp=1/0/0", display_enable, pixel_x, pixel_y); end
    endtask

    task automatic test_default_mode;
        measure_frame();
        total++; if (m_period !== 120) begin bad++; $display("FAIL a_period got=%0d exp=120", m_period); end
        total++; if (m_de !== 32) begin bad++; $display("FAIL a_de got=%0d exp=32", m_de); end
        total++; if (m_hs !== 24 || m_hs_first !== 10) begin bad++; $display("FAIL a_hsync got=%0d@%0d exp=24@10", m_hs, m_hs_first); end
        total++; if (m_vs !== 30 || m_vs_first !== 75) begin bad++; $display("FAIL a_vsync got=%0d@%0d exp=30@75", m_vs, m_vs_first); end
        total++; if (m_vbs_off !== 60) begin bad++; $display("FAIL a_vblank got=%0d exp=60", m_vbs_off); end
        total++; if (m_ls !== 4) begin bad++; $display("FAIL a_line_start got=%0d exp=4", m_ls); end
        total++; if (px[3] !== 3 || py[3] !== 0 || px[17] !== 2 || py[17] !== 1) begin bad++; $display("FAIL a_coord got=%0d,%0d %0d,%0d exp=3,0 2,1", px[3], py[3], px[17], py[17]); end
        total++; if (px[52] !== 7 || py[52] !== 3 || px[9] !== 0 || px[62] !== 0 || py[62] !== 0) begin bad++; $display("FAIL a_blank_coord got=%0d,%0d %0d %0d,%0d exp=7,3 0 0,0", px[52], py[52], px[9], px[62], py[62]); end
        total++; if (m_phs_hi !== 24 || m_pneq !== 0) begin bad++; $display("FAIL pol_hsync got=%0d/%0d exp=24/0", m_phs_hi, m_pneq); end
    endtask

    task automatic test_alignment;
        logic [2*CW:0] hist [0:299];
        int mism;
        mism = 0;
        for (int t = 0; t < 300; t++) begin
            hist[t] = {fetch_valid, fetch_x, fetch_y};
            if (t >= 4 && {display_enable, pixel_x, pixel_y} !== hist[t-4]) mism++;
            tick();
        end
        total++; if (mism !== 0) begin bad++; $display("FAIL align got=%0d mismatching cycles exp=0", mism); end
    endtask

    task automatic test_cfg_switch;
        int w, i, rise;
        w = 0;
        while (frame_start !== 1'b1 && w < 500) begin tick(); w++; end
        i = 0; rise = -1;
        while (i < 400) begin
            tick(); i++;
            if (i == 30) drive_cfg(1'b1, 6, 1, 2, 3, 3, 1, 1, 2);
            if (i == 31) begin
                total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_accept got=%b exp=0", cfg_if.cfg_ready); end
                cfg_if.cfg_valid = 1'b0;
            end
            if (i == 40) drive_cfg(1'b1, 5, 0, 0, 1, 2, 0, 0, 1);
            if (i == 50) cfg_if.cfg_valid = 1'b0;
            if (i > 31 && cfg_if.cfg_ready === 1'b1 && rise < 0) rise = i;
            if (frame_start === 1'b1) break;
        end
        total++; if (i !== 120) begin bad++; $display("FAIL cfg_old_frame got=%0d exp=120", i); end
        total++; if (rise !== 115) begin bad++; $display("FAIL cfg_ready_rise got=%0d exp=115", rise); end
        measure_frame();
        total++; if (m_period !== 84) begin bad++; $display("FAIL b_period got=%0d exp=84", m_period); end
        total++; if (m_de !== 18 || m_ls !== 3) begin bad++; $display("FAIL b_active got=%0d/%0d exp=18/3", m_de, m_ls); end
        total++; if (m_hs !== 14 || m_hs_first !== 7) begin bad++; $display("FAIL b_hsync got=%0d@%0d exp=14@7", m_hs, m_hs_first); end
        total++; if (m_vs !== 12 || m_vs_first !== 48 || m_vbs_off !== 36) begin bad++; $display("FAIL b_vert got=%0d@%0d vb=%0d exp=12@48 vb=36", m_vs, m_vs_first, m_vbs_off); end
        measure_frame();
        total++; if (m_period !== 84) begin bad++; $display("FAIL b_second_offer got=%0d exp=84", m_period); end
    endtask

    task automatic test_eof_offer;
        int i;
        i = 0;
        while (i < 400) begin
            tick(); i++;
            if (i == 78) drive_cfg(1'b1, 8, 2, 3, 2, 4, 1, 2, 1);
            if (i == 79) begin
                total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL eof_accept got=%b exp=0", cfg_if.cfg_ready); end
                cfg_if.cfg_valid = 1'b0;
            end
            if (frame_start === 1'b1) break;
        end
        total++; if (i !== 84) begin bad++; $display("FAIL eof_cur_frame got=%0d exp=84", i); end
        measure_frame();
        total++; if (m_period !== 84) begin bad++; $display("FAIL eof_next_frame got=%0d exp=84", m_period); end
        measure_frame();
        total++; if (m_period !== 120) begin bad++; $display("FAIL eof_applied got=%0d exp=120", m_period); end
    endtask

    task automatic test_zero_segments;
        int i;
        i = 0;
        while (i < 400) begin
            tick(); i++;
            if (i == 10) drive_cfg(1'b1, 5, 0, 0, 1, 2, 0, 0, 1);
            if (i == 11) cfg_if.cfg_valid = 1'b0;
            if (frame_start === 1'b1) break;
        end
        measure_frame();
        total++; if (m_period !== 18) begin bad++; $display("FAIL c_period got=%0d exp=18", m_period); end
        total++; if (m_de !== 10 || m_ls !== 2 || m_vbs_off !== 12) begin bad++; $display("FAIL c_active got=%0d/%0d vb=%0d exp=10/2 vb=12", m_de, m_ls, m_vbs_off); end
        total++; if (m_hs !== 0 || m_vs !== 0) begin bad++; $display("FAIL c_no_sync got=%0d/%0d exp=0/0", m_hs, m_vs); end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        tick();
        drive_cfg(1'b1, 6, 1, 2, 3, 3, 1, 1, 2);
        tick();
        cfg_if.cfg_valid = 1'b0;
        repeat (3) tick();
        total++; if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_pending got=%b exp=0", cfg_if.cfg_ready); end
        rst_n = 1'b0;
        tick();
        total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", cfg_if.cfg_ready); end
        total++; if ({fetch_valid, display_enable, frame_start, vblank_start, hsync, vsync} !== 6'b000011) begin bad++; $display("FAIL mid_rst_outs got=%b exp=000011", {fetch_valid, display_enable, frame_start, vblank_start, hsync, vsync}); end
        total++; if ({fetch_x, fetch_y, pixel_x, pixel_y} !== '0) begin bad++; $display("FAIL mid_rst_coords got=%h exp=0", {fetch_x, fetch_y, pixel_x, pixel_y}); end
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 50) begin tick(); n++; end
        total++; if (n !== 5) begin bad++; $display("FAIL mid_first_fs got=%0d exp=5", n); end
        measure_frame();
        total++; if (m_period !== 120) begin bad++; $display("FAIL mid_def_mode got=%0d exp=120", m_period); end
        measure_frame();
        total++; if (m_period !== 120) begin bad++; $display("FAIL mid_shadow_dropped got=%0d exp=120", m_period); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_default_mode();
        test_alignment();
        test_cfg_switch();
        test_eof_offer();
        test_zero_segments();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
